// File: rtl/ifu_pkg.sv
// Shared constants and payload types for the instruction-fetch queue.
package ifu_pkg;

    localparam logic [31:0] ADDR_BASE_DEF = 32'h0000_3000;
    localparam logic [31:0] ADDR_END_DEF  = 32'h0000_7000;
    localparam int unsigned WORD_IDX_W    = 12;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// PC, instruction-ROM and decode-side signals of the fetch queue.
// master = surrounding pipeline/ROM, slave = ifu_fetch_queue.
interface ifu_fetch_queue_if;
    import ifu_pkg::*;

    logic [31:0]           pc_i;
    logic                  pc_valid_i;
    logic                  pc_ready_o;
    logic                  imem_req_o;
    logic [WORD_IDX_W-1:0] imem_addr_o;
    logic [31:0]           imem_rdata_i;
    logic                  redirect_i;
    logic                  instr_valid_o;
    logic [31:0]           instr_o;
    logic [31:0]           instr_pc_o;
    logic                  instr_ready_i;
    logic                  halt_o;
    logic                  fault_o;

    modport master (
        output pc_i, pc_valid_i, imem_rdata_i, redirect_i, instr_ready_i,
        input  pc_ready_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o,
               instr_pc_o, halt_o, fault_o
    );

    modport slave (
        input  pc_i, pc_valid_i, imem_rdata_i, redirect_i, instr_ready_i,
        output pc_ready_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o,
               instr_pc_o, halt_o, fault_o
    );

endinterface

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with flush; push and pop may coincide at any occupancy.
module ifu_sync_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output entry_t           head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_en;

    assign pop_en = pop_i && (count_q != '0);

    // Pointer/occupancy update; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch queue: PC accept, ROM request, instruction FIFO to decode.
// Define IFU_BYPASS_EN to forward returning ROM data straight to decode when empty.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF,
    parameter logic [31:0] ADDR_END  = ADDR_END_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    ifu_fetch_queue_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;
    fetch_entry_t     head, push_data, out_entry;
    logic             ready_en_q;
    logic             inflight_q, inflight_d;
    logic             halt_q, halt_d;
    logic             fault_q, fault_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [31:0]      pc_off;
    logic             is_end, in_win, credit_ok, accept, req;
    logic             ret_valid, push, pop, out_valid;

    assign is_end    = (bus.pc_i == ADDR_END);
    assign in_win    = (bus.pc_i[1:0] == 2'b00) && (bus.pc_i >= ADDR_BASE) && (bus.pc_i < ADDR_END);
    // In-flight data holds a slot so a returning word always has room.
    assign credit_ok = (count + CNT_W'(inflight_q)) < CNT_W'(DEPTH);

    assign bus.pc_ready_o = ready_en_q && !halt_q && !fault_q && !bus.redirect_i && credit_ok;
    assign accept         = bus.pc_valid_i && bus.pc_ready_o;
    assign req            = accept && in_win;
    assign pc_off         = bus.pc_i - ADDR_BASE;
    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = WORD_IDX_W'(pc_off >> 2);

    assign ret_valid = inflight_q && !bus.redirect_i;
    assign push_data = '{pc: pend_pc_q, instr: bus.imem_rdata_i};
    assign pop       = bus.instr_ready_i && (count != '0);

`ifdef IFU_BYPASS_EN
    logic bypass;
    assign bypass    = ret_valid && (count == '0);
    assign push      = ret_valid && !(bypass && bus.instr_ready_i);
    assign out_valid = bypass || (count != '0);
    assign out_entry = bypass ? push_data : head;
`else
    assign push      = ret_valid;
    assign out_valid = (count != '0);
    assign out_entry = head;
`endif

    assign bus.instr_valid_o = out_valid;
    assign bus.instr_o       = out_valid ? out_entry.instr : '0;
    assign bus.instr_pc_o    = out_valid ? out_entry.pc : '0;
    assign bus.halt_o        = halt_q;
    assign bus.fault_o       = fault_q;

    always_comb begin
        inflight_d = req;
        pend_pc_d  = pend_pc_q;
        halt_d     = halt_q;
        fault_d    = fault_q;
        if (req) pend_pc_d = bus.pc_i;
        if (accept && is_end) halt_d = 1'b1;
        if (accept && !is_end && !in_win) fault_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            inflight_q <= 1'b0;
            pend_pc_q  <= '0;
            halt_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            inflight_q <= inflight_d;
            pend_pc_q  <= pend_pc_d;
            halt_q     <= halt_d;
            fault_q    <= fault_d;
        end
    end

    ifu_sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (bus.redirect_i),
        .count_o     (count),
        .head_o      (head)
    );

endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Instruction-fetch queue sitting between the program counter register and the decode stage. It accepts the PC value each cycle, issues word reads to the synchronous instruction ROM, and buffers returned instructions with their PCs in a small FIFO for decode. It supports pipeline-redirect flushes and halts cleanly at the end of the 0x00003000–0x00006FFF instruction window.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- ADDR_BASE, 32'h00003000: first valid instruction address.
- ADDR_END, 32'h00007000: first address past the window; fetching it halts.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- pc_i  input  32  address offered by the PC register.
- pc_valid_i  input  1  pc_i is valid this cycle.
- pc_ready_o  output  1  block accepts pc_i this cycle.
- imem_req_o  output  1  ROM read enable.
- imem_addr_o  output  12  ROM word index, (pc_i - ADDR_BASE) >> 2.
- imem_rdata_i  input  32  ROM data, valid the cycle after imem_req_o.
- redirect_i  input  1  flush request from branch/jump resolution.
- instr_valid_o  output  1  instr_o/instr_pc_o valid.
- instr_o  output  32  instruction word.
- instr_pc_o  output  32  PC of instr_o.
- instr_ready_i  input  1  decode consumes the head entry.
- halt_o  output  1  sticky; ADDR_END was accepted.
- fault_o  output  1  sticky; misaligned or out-of-window PC was accepted.

## Operation
- Accept = pc_valid_i & pc_ready_o.
- pc_ready_o = !halt_o & !fault_o & !redirect_i & (count + inflight < DEPTH). count is FIFO occupancy, inflight is 0/1.
- Accept of an in-window, word-aligned PC: imem_req_o=1 combinationally, inflight set, pc_i captured into pend_pc.
- Accept of pc_i == ADDR_END: no ROM request; halt_o set. Accept of a misaligned PC or a PC outside the window: no ROM request; fault_o set. After either flag is set, pc_ready_o stays low until reset.
- The cycle after a request: {pend_pc, imem_rdata_i} is pushed into the FIFO. Push and pop in the same cycle are both allowed at any occupancy.
- Pop = instr_valid_o & instr_ready_i.
- redirect_i: FIFO emptied, inflight cleared, and any ROM data returning the next cycle is discarded. No accept occurs in the redirect cycle. halt_o and fault_o are not cleared.
- Credit accounting counts in-flight data, so the FIFO can never overflow. instr_valid_o = (count != 0).
- Reset: all outputs 0, FIFO pointers 0, inflight 0, halt_o and fault_o 0. pc_ready_o rises in the first cycle after rst_n deasserts. Asserting reset mid-operation drops all state immediately.

## Timing
- Cycle 0: pc_i accepted. Cycle 1: ROM data valid and pushed. Cycle 2: instr_valid_o=1 (latency 2 without bypass).
- Sustained throughput is 1 instruction/cycle when instr_ready_i is held high and DEPTH ≥ 3.
- A redirect in cycle N leaves instr_valid_o=0 in cycle N+1. A new PC can be accepted in cycle N+1.
- halt_o and fault_o go high in the cycle after the offending accept.

## Configuration
- IFU_BYPASS_EN defined:
  - When the FIFO is empty, the returning ROM data drives instr_o/instr_pc_o directly in cycle 1, with instr_valid_o=1.
  - If instr_ready_i=1, the word is consumed without a push; otherwise it is pushed.
  - A redirect in cycle 1 suppresses the bypassed word.
  - Latency is 1.
- IFU_BYPASS_EN undefined: all data passes through the FIFO; latency is 2.

## Structure
- Package ifu_pkg:
  - ADDR_BASE_DEF and ADDR_END_DEF constants.
  - fetch_entry_t typedef: {pc[31:0], instr[31:0]}.
  - Word-index width localparam (12).
- Sub-module ifu_sync_fifo:
  - Parameterised DEPTH and entry type.
  - Signals: push, pop, flush, count, head out.
  - Async active-low reset.

## Test plan
- Reset, then offer 0x3000, 0x3004, 0x3008 back-to-back with instr_ready_i=1 and ROM[i]=0x1000+i -> instr_o 0x1000, 0x1001, 0x1002 with matching PCs; first instruction appears in cycle 2 (cycle 1 with IFU_BYPASS_EN).
- Hold instr_ready_i=0, offer PCs continuously -> exactly DEPTH entries accepted; pc_ready_o drops and stays low. Pulse instr_ready_i once -> exactly one more PC accepted.
- Redirect in the cycle after accepting 0x3010 with 2 entries queued -> instr_valid_o=0 next cycle, the 0x3010 data never appears. Then offer 0x3100 -> it is the next PC delivered.
- Offer 0x6FFC then 0x7000 -> 0x6FFC instruction delivered; halt_o=1; pc_ready_o=0; imem_req_o never asserted for 0x7000.
- Offer 0x3002 (and separately 0x2FFC) -> fault_o=1, no ROM request, no FIFO push.
- Assert rst_n low mid-stream with 3 entries queued -> instr_valid_o, halt_o, fault_o immediately 0; after release, fetching resumes from the next offered PC.
